// File: rtl/vm1_bus_target.sv
// VM1 Q-bus style target: decodes an address window, turns DIN/DOUT strobes into
// request/acknowledge memory transactions and answers with RPLY after optional wait states.
module vm1_bus_target #(
   parameter logic [15:0] BASE_ADDR   = 16'h8000,
   parameter logic [15:0] ADDR_MASK   = 16'hC000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        pin_clk,
   input  logic        pin_dclo,
   input  logic [15:0] bus_addr,
   input  logic        bus_sync,
   input  logic        bus_din,
   input  logic        bus_dout,
   input  logic [1:0]  bus_wtbt,
   input  logic [15:0] bus_wdata,
   output logic [15:0] bus_rdata,
   output logic        bus_rply,
   output logic        bus_sel,
   output logic [14:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [1:0]  mem_be,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SEL    = 3'd1;
   localparam logic [2:0] ST_RD_REQ = 3'd2;
   localparam logic [2:0] ST_WR_REQ = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_RPLY   = 3'd5;
   localparam logic [2:0] ST_DRAIN  = 3'd6;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   logic [2:0]  state_r;
   logic        sync_r;
   logic [3:0]  wait_cnt_r;
   logic [15:0] rdata_r;
   logic        is_rd_r;

   logic        rise_s;
   logic        hit_s;
   logic        strobe_s;

   assign rise_s   = bus_sync & ~sync_r;
   assign hit_s    = ((bus_addr ^ BASE_ADDR) & ADDR_MASK) == 16'h0000;
   // The strobe that opened the current data phase; its fall ends the reply.
   assign strobe_s = is_rd_r ? bus_din : bus_dout;

   // Bus-cycle state machine with all outputs registered.
   always_ff @(posedge pin_clk or posedge pin_dclo) begin
      if (pin_dclo) begin
         state_r    <= ST_IDLE;
         sync_r     <= 1'b0;
         wait_cnt_r <= 4'd0;
         rdata_r    <= 16'h0000;
         is_rd_r    <= 1'b0;
         bus_rdata  <= 16'h0000;
         bus_rply   <= 1'b0;
         bus_sel    <= 1'b0;
         mem_addr   <= 15'h0000;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_be     <= 2'b00;
         mem_wdata  <= 16'h0000;
      end else begin
         sync_r <= bus_sync;
         case (state_r)
            ST_IDLE: begin
               if (rise_s && hit_s) begin
                  mem_addr <= bus_addr[15:1];
                  bus_sel  <= 1'b1;
                  state_r  <= ST_SEL;
               end
            end
            ST_SEL: begin
               if (!bus_sync) begin
                  bus_sel <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (bus_din) begin
                  mem_rd  <= 1'b1;
                  is_rd_r <= 1'b1;
                  state_r <= ST_RD_REQ;
               end else if (bus_dout) begin
                  mem_wr    <= 1'b1;
                  is_rd_r   <= 1'b0;
                  mem_wdata <= bus_wdata;
                  mem_be    <= (bus_wtbt == 2'b00) ? 2'b11 : bus_wtbt;
                  state_r   <= ST_WR_REQ;
               end
            end
            ST_RD_REQ, ST_WR_REQ: begin
               if (mem_ack) begin
                  mem_rd     <= 1'b0;
                  mem_wr     <= 1'b0;
                  rdata_r    <= is_rd_r ? mem_rdata : 16'h0000;
                  wait_cnt_r <= WAIT_INIT;
                  if (!bus_sync) begin
                     bus_sel <= 1'b0;
                     state_r <= ST_IDLE;
                  end else if (WAIT_INIT == 4'd0) begin
                     bus_rply  <= 1'b1;
                     bus_rdata <= is_rd_r ? mem_rdata : 16'h0000;
                     state_r   <= ST_RPLY;
                  end else begin
                     state_r <= ST_WAIT;
                  end
               end else if (!bus_sync) begin
                  // CPU gave up; keep the request until memory finishes it.
                  bus_sel <= 1'b0;
                  state_r <= ST_DRAIN;
               end
            end
            ST_WAIT: begin
               if (!bus_sync) begin
                  wait_cnt_r <= 4'd0;
                  bus_sel    <= 1'b0;
                  state_r    <= ST_IDLE;
               end else if (wait_cnt_r <= 4'd1) begin
                  wait_cnt_r <= 4'd0;
                  bus_rply   <= 1'b1;
                  bus_rdata  <= rdata_r;
                  state_r    <= ST_RPLY;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
            ST_RPLY: begin
               if (!strobe_s) begin
                  bus_rply  <= 1'b0;
                  bus_rdata <= 16'h0000;
                  if (bus_sync) begin
                     state_r <= ST_SEL;
                  end else begin
                     bus_sel <= 1'b0;
                     state_r <= ST_IDLE;
                  end
               end
            end
            ST_DRAIN: begin
               if (mem_ack) begin
                  mem_rd  <= 1'b0;
                  mem_wr  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               mem_rd    <= 1'b0;
               mem_wr    <= 1'b0;
               bus_rply  <= 1'b0;
               bus_rdata <= 16'h0000;
               bus_sel   <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vm1_bus_target.sv
// Directed bench for vm1_bus_target: two targets on one bus, zero and three wait states.
module tb_vm1_bus_target;

   logic        pin_clk;
   logic        pin_dclo;
   logic [15:0] bus_addr;
   logic        bus_sync;
   logic        bus_din;
   logic        bus_dout;
   logic [1:0]  bus_wtbt;
   logic [15:0] bus_wdata;

   logic [15:0] bus_rdata0, bus_rdata1;
   logic        bus_rply0, bus_rply1;
   logic        bus_sel0, bus_sel1;
   logic [14:0] mem_addr0, mem_addr1;
   logic        mem_rd0, mem_rd1;
   logic        mem_wr0, mem_wr1;
   logic [1:0]  mem_be0, mem_be1;
   logic [15:0] mem_wdata0, mem_wdata1;
   logic [15:0] mem_rdata0, mem_rdata1;
   logic        mem_ack0, mem_ack1;

   int n_checks;
   int n_errors;

   vm1_bus_target #(.BASE_ADDR(16'h8000), .ADDR_MASK(16'hC000), .WAIT_STATES(0)) dut0 (
      .pin_clk(pin_clk), .pin_dclo(pin_dclo), .bus_addr(bus_addr), .bus_sync(bus_sync),
      .bus_din(bus_din), .bus_dout(bus_dout), .bus_wtbt(bus_wtbt), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata0), .bus_rply(bus_rply0), .bus_sel(bus_sel0), .mem_addr(mem_addr0),
      .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_be(mem_be0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata0), .mem_ack(mem_ack0)
   );

   vm1_bus_target #(.BASE_ADDR(16'hC000), .ADDR_MASK(16'hC000), .WAIT_STATES(3)) dut1 (
      .pin_clk(pin_clk), .pin_dclo(pin_dclo), .bus_addr(bus_addr), .bus_sync(bus_sync),
      .bus_din(bus_din), .bus_dout(bus_dout), .bus_wtbt(bus_wtbt), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata1), .bus_rply(bus_rply1), .bus_sel(bus_sel1), .mem_addr(mem_addr1),
      .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_be(mem_be1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .mem_ack(mem_ack1)
   );

   initial pin_clk = 1'b0;
   always #5 pin_clk = ~pin_clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pin_clk);
      #1;
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      pin_dclo   = 1'b1;
      bus_addr   = 16'h0000;
      bus_sync   = 1'b0;
      bus_din    = 1'b0;
      bus_dout   = 1'b0;
      bus_wtbt   = 2'b11;
      bus_wdata  = 16'h0000;
      mem_rdata0 = 16'h0000;
      mem_rdata1 = 16'h0000;
      mem_ack0   = 1'b0;
      mem_ack1   = 1'b0;
      #2;
      check("rst_rply",  {31'd0, bus_rply0}, 32'd0);
      check("rst_sel",   {31'd0, bus_sel0}, 32'd0);
      check("rst_rdata", {16'd0, bus_rdata0}, 32'd0);
      check("rst_memrd", {31'd0, mem_rd0}, 32'd0);
      tick();
      tick();
      pin_dclo = 1'b0;
      tick();

      // Word read, zero wait states
      bus_addr = 16'h8010; bus_sync = 1'b1;
      tick();
      check("rd_sel",   {31'd0, bus_sel0}, 32'd1);
      check("rd_addr",  {17'd0, mem_addr0}, 32'h4008);
      bus_din = 1'b1;
      tick();
      check("rd_req",   {31'd0, mem_rd0}, 32'd1);
      check("rd_norply", {31'd0, bus_rply0}, 32'd0);
      mem_ack0 = 1'b1; mem_rdata0 = 16'h1234;
      tick();
      mem_ack0 = 1'b0; mem_rdata0 = 16'h0000;
      check("rd_rply",  {31'd0, bus_rply0}, 32'd1);
      check("rd_data",  {16'd0, bus_rdata0}, 32'h1234);
      check("rd_reqoff", {31'd0, mem_rd0}, 32'd0);
      tick();
      check("rd_hold",  {31'd0, bus_rply0}, 32'd1);
      check("rd_holdd", {16'd0, bus_rdata0}, 32'h1234);
      bus_din = 1'b0;
      tick();
      check("rd_rplyoff", {31'd0, bus_rply0}, 32'd0);
      check("rd_dataoff", {16'd0, bus_rdata0}, 32'h0000);
      bus_sync = 1'b0;
      tick();
      check("rd_seloff", {31'd0, bus_sel0}, 32'd0);

      // Byte write, high lane
      bus_addr = 16'h8003; bus_sync = 1'b1;
      tick();
      check("bw_addr", {17'd0, mem_addr0}, 32'h4001);
      bus_dout = 1'b1; bus_wtbt = 2'b10; bus_wdata = 16'hAB00;
      tick();
      check("bw_wr",    {31'd0, mem_wr0}, 32'd1);
      check("bw_rd",    {31'd0, mem_rd0}, 32'd0);
      check("bw_be",    {30'd0, mem_be0}, 32'd2);
      check("bw_wdata", {16'd0, mem_wdata0}, 32'hAB00);
      bus_wdata = 16'h0000;
      tick();
      check("bw_held",   {31'd0, mem_wr0}, 32'd1);
      check("bw_stable", {16'd0, mem_wdata0}, 32'hAB00);
      mem_ack0 = 1'b1;
      tick();
      mem_ack0 = 1'b0;
      check("bw_rply",  {31'd0, bus_rply0}, 32'd1);
      check("bw_wroff", {31'd0, mem_wr0}, 32'd0);
      check("bw_rdata", {16'd0, bus_rdata0}, 32'h0000);
      bus_dout = 1'b0;
      tick();
      check("bw_rplyoff", {31'd0, bus_rply0}, 32'd0);
      bus_sync = 1'b0; bus_wtbt = 2'b11;
      tick();

      // Read-modify-write under one SYNC, write with wtbt=00
      bus_addr = 16'h8000; bus_sync = 1'b1;
      tick();
      bus_din = 1'b1;
      tick();
      check("rmw_rd",   {31'd0, mem_rd0}, 32'd1);
      check("rmw_addr", {17'd0, mem_addr0}, 32'h4000);
      mem_ack0 = 1'b1; mem_rdata0 = 16'h00FF;
      tick();
      mem_ack0 = 1'b0; mem_rdata0 = 16'h0000;
      check("rmw_rply1", {31'd0, bus_rply0}, 32'd1);
      check("rmw_data",  {16'd0, bus_rdata0}, 32'h00FF);
      bus_din = 1'b0;
      tick();
      check("rmw_gap",  {31'd0, bus_rply0}, 32'd0);
      check("rmw_sel",  {31'd0, bus_sel0}, 32'd1);
      bus_dout = 1'b1; bus_wtbt = 2'b00; bus_wdata = 16'h0F0F;
      tick();
      check("rmw_wr",    {31'd0, mem_wr0}, 32'd1);
      check("rmw_rdoff", {31'd0, mem_rd0}, 32'd0);
      check("rmw_waddr", {17'd0, mem_addr0}, 32'h4000);
      check("rmw_be",    {30'd0, mem_be0}, 32'd3);
      check("rmw_wdata", {16'd0, mem_wdata0}, 32'h0F0F);
      mem_ack0 = 1'b1;
      tick();
      mem_ack0 = 1'b0;
      check("rmw_rply2", {31'd0, bus_rply0}, 32'd1);
      check("rmw_sel2",  {31'd0, bus_sel0}, 32'd1);
      bus_dout = 1'b0; bus_wtbt = 2'b11;
      tick();
      check("rmw_end", {31'd0, bus_rply0}, 32'd0);
      bus_sync = 1'b0;
      tick();
      check("rmw_seloff", {31'd0, bus_sel0}, 32'd0);

      // Miss on both targets
      bus_addr = 16'h4000; bus_sync = 1'b1;
      tick();
      check("miss_sel0", {31'd0, bus_sel0}, 32'd0);
      check("miss_sel1", {31'd0, bus_sel1}, 32'd0);
      bus_din = 1'b1;
      tick();
      tick();
      check("miss_rd",   {30'd0, mem_rd0, mem_rd1}, 32'd0);
      check("miss_rply", {30'd0, bus_rply0, bus_rply1}, 32'd0);
      bus_din = 1'b0; bus_sync = 1'b0;
      tick();

      // Three wait states on the second target
      bus_addr = 16'hC010; bus_sync = 1'b1;
      tick();
      check("ws_sel",  {30'd0, bus_sel0, bus_sel1}, 32'd1);
      check("ws_addr", {17'd0, mem_addr1}, 32'h6008);
      bus_din = 1'b1;
      tick();
      check("ws_rd", {31'd0, mem_rd1}, 32'd1);
      mem_ack1 = 1'b1; mem_rdata1 = 16'hBEEF;
      tick();
      mem_ack1 = 1'b0; mem_rdata1 = 16'h0000;
      check("ws_ack0", {31'd0, bus_rply1}, 32'd0);
      check("ws_rdoff", {31'd0, mem_rd1}, 32'd0);
      tick();
      check("ws_ack1", {31'd0, bus_rply1}, 32'd0);
      tick();
      check("ws_ack2", {31'd0, bus_rply1}, 32'd0);
      tick();
      check("ws_ack3", {31'd0, bus_rply1}, 32'd1);
      check("ws_data", {16'd0, bus_rdata0 | bus_rdata1}, 32'hBEEF);
      bus_din = 1'b0;
      tick();
      check("ws_end", {31'd0, bus_rply1}, 32'd0);
      bus_sync = 1'b0;
      tick();

      // SYNC dropped while a read is pending
      bus_addr = 16'h8020; bus_sync = 1'b1;
      tick();
      bus_din = 1'b1;
      tick();
      check("ab_rd", {31'd0, mem_rd0}, 32'd1);
      bus_sync = 1'b0; bus_din = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ab_held", {31'd0, mem_rd0}, 32'd1);
         check("ab_norply", {31'd0, bus_rply0}, 32'd0);
      end
      check("ab_seloff", {31'd0, bus_sel0}, 32'd0);
      mem_ack0 = 1'b1; mem_rdata0 = 16'hDEAD;
      tick();
      mem_ack0 = 1'b0; mem_rdata0 = 16'h0000;
      check("ab_rdoff",  {31'd0, mem_rd0}, 32'd0);
      check("ab_norply2", {31'd0, bus_rply0}, 32'd0);
      check("ab_nodata", {16'd0, bus_rdata0}, 32'h0000);
      tick();
      bus_addr = 16'h8022; bus_sync = 1'b1;
      tick();
      check("ab_next_addr", {17'd0, mem_addr0}, 32'h4011);
      bus_din = 1'b1;
      tick();
      mem_ack0 = 1'b1; mem_rdata0 = 16'h5555;
      tick();
      mem_ack0 = 1'b0; mem_rdata0 = 16'h0000;
      check("ab_next_rply", {31'd0, bus_rply0}, 32'd1);
      check("ab_next_data", {16'd0, bus_rdata0}, 32'h5555);

      // Asynchronous reset while replying
      #1;
      pin_dclo = 1'b1; bus_sync = 1'b0; bus_din = 1'b0;
      #1;
      check("ar_rply",  {31'd0, bus_rply0}, 32'd0);
      check("ar_sel",   {31'd0, bus_sel0}, 32'd0);
      check("ar_rdata", {16'd0, bus_rdata0}, 32'h0000);
      check("ar_maddr", {17'd0, mem_addr0}, 32'h0000);
      check("ar_mreq",  {30'd0, mem_rd0, mem_wr0}, 32'd0);
      #1;
      pin_dclo = 1'b0;
      tick();
      check("ar_idle", {31'd0, bus_sel0}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vm1_bus_target.md
Name: vm1_bus_target

Overview:
- Bus responder (slave end) for the VM1 CPU's demultiplexed Q-bus-style interface: SYNC, DIN, DOUT, WTBT, RPLY.
- Decodes the latched address against a window and converts each DIN/DOUT strobe into a request/acknowledge transaction on a simple synchronous memory/register port.
- Returns RPLY once the transaction completes, with programmable wait states.
- Supports word, byte and read-modify-write cycles. Several instances share one CPU bus; their read data is OR-combined.

Parameters:
- BASE_ADDR, 16'h8000, window base address (byte address).
- ADDR_MASK, 16'hC000, address bits compared against BASE_ADDR.
- WAIT_STATES, 0, extra clocks (0..15) inserted between mem_ack and bus_rply assertion.

Ports:
- pin_clk  in  1  processor clock; all logic on the rising edge.
- pin_dclo  in  1  asynchronous reset, active-high.
- bus_addr  in  16  latched bus address.
- bus_sync  in  1  address strobe; high for the whole bus cycle.
- bus_din  in  1  CPU read strobe.
- bus_dout  in  1  CPU write strobe.
- bus_wtbt  in  2  byte-lane enables, active-high: [0] low byte, [1] high byte; 2'b11 means word.
- bus_wdata  in  16  CPU write data.
- bus_rdata  out  16  read data; zero when not driving, so outputs can be OR-combined.
- bus_rply  out  1  transaction reply.
- bus_sel  out  1  this target is selected for the current SYNC cycle.
- mem_addr  out  15  word address (bus_addr[15:1]).
- mem_rd  out  1  read request, level; held until mem_ack.
- mem_wr  out  1  write request, level; held until mem_ack.
- mem_be  out  2  byte enables for mem_wr.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid in the cycle mem_ack=1.
- mem_ack  in  1  one-cycle completion pulse. May arrive in the first cycle the request is visible.

Behaviour:
- All outputs are registered.
- pin_dclo=1 immediately forces state IDLE and every output to 0; the wait counter clears.
- sync_q registers bus_sync each clock. A rising edge is defined as bus_sync=1 & sync_q=0.
- In IDLE, on a rising edge: hit = ((bus_addr ^ BASE_ADDR) & ADDR_MASK) == 0.
  - On hit: latch mem_addr = bus_addr[15:1], set bus_sel=1, go to SEL.
  - On miss: stay in IDLE and never assert bus_rply; another target responds, or the CPU times out.
- SEL:
  - bus_din=1 → RD_REQ, mem_rd=1.
  - Otherwise bus_dout=1 → WR_REQ, mem_wr=1; mem_wdata=bus_wdata and mem_be=bus_wtbt (2'b00 is treated as 2'b11) are latched in the same cycle.
  - DIN has priority if both strobes are high.
  - bus_sync=0 → IDLE, bus_sel=0.
- RD_REQ / WR_REQ:
  - Request held until mem_ack.
  - On mem_ack: drop the request; for reads capture mem_rdata; load wait counter = WAIT_STATES; go to WAIT.
- WAIT: decrement the counter each clock. At 0, set bus_rply=1, drive bus_rdata = captured data (reads only), go to RPLY.
- With WAIT_STATES=0, WAIT is skipped: bus_rply=1 and bus_rdata valid after the mem_ack edge.
- Minimum latency: strobe sampled at edge N, mem_ack at N+1, bus_rply visible after N+1 (2 clocks).
- RPLY: hold bus_rply and bus_rdata until the active strobe is sampled low. At that edge, bus_rply=0 and bus_rdata=0. Then:
  - bus_sync=1 → SEL. This enables the DOUT half of a read-modify-write under the same SYNC; mem_addr is unchanged.
  - bus_sync=0 → IDLE, bus_sel=0.
- SYNC dropped in RD_REQ/WR_REQ:
  - Go to DRAIN; the request stays held until mem_ack. bus_rply is never asserted and read data is discarded.
  - Then go to IDLE.
  - A new rising SYNC during DRAIN is not decoded; the target ignores that cycle.
- SYNC dropped in WAIT: abort to IDLE with no reply; bus_sel=0.
- mem_rd and mem_wr are never both high. mem_addr, mem_be and mem_wdata stay stable while a request is high.

Test Plan:
- Word read: WAIT_STATES=0, bus_addr=16'h8010, SYNC then DIN, mem_ack 1 clock after mem_rd with mem_rdata=16'h1234 → mem_addr=15'h4008; bus_rply high 2 clocks after DIN sampled; bus_rdata=16'h1234; both return to 0 one clock after DIN falls.
- Byte write: bus_addr=16'h8003, bus_wtbt=2'b10, bus_wdata=16'hAB00, DOUT → mem_wr with mem_be=2'b10 and mem_wdata=16'hAB00; bus_rply after mem_ack.
- RMW: single SYNC, DIN read returning 16'h00FF, then DOUT write 16'h0F0F → one mem_rd then one mem_wr, both at mem_addr=15'h4000; two separate bus_rply pulses; bus_sel high throughout.
- Miss and wait states: bus_addr=16'h4000 → no mem_rd, bus_rply and bus_sel stay 0. With WAIT_STATES=3 on a hit, bus_rply is asserted exactly 3 clocks after the mem_ack edge.
- Abort: SYNC drops while mem_rd is pending, mem_ack 4 clocks later → mem_rd held until mem_ack; bus_rply never asserted; IDLE afterwards; the next hit cycle completes normally.
- Reset: pin_dclo pulse while bus_rply=1 → bus_rply, bus_sel, bus_rdata and mem_* are 0 immediately, without waiting for a clock edge.
